// File: rtl/tia_multiphase_clock_pkg.sv
`default_nettype none
// =============================================================================
// Module : tia_multiphase_clock_pkg
// Shared state encoding and width helpers for the TIA multiphase clock.
// Rev    : 1.0
// =============================================================================
package tia_multiphase_clock_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2
    } state_t;

    function automatic int phase_width(input int num_phases);
        return (num_phases > 2) ? $clog2(num_phases) : 1;
    endfunction

    // Window counter must hold the larger of the ON and OFF terminal counts.
    function automatic int cnt_width(input int on_cycles, input int off_cycles);
        return $clog2(((on_cycles > off_cycles) ? on_cycles : off_cycles) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tia_multiphase_clock_sync_sr.sv
`default_nettype none
// =============================================================================
// Module : tia_multiphase_clock_sync_sr
// Synchronous set/reset flop, reset dominant over set.
// Rev    : 1.0
// =============================================================================
module tia_multiphase_clock_sync_sr (
    input  logic clk,
    input  logic r,
    input  logic s,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (r) begin
            r_q <= 1'b0;
        end else if (s) begin
            r_q <= 1'b1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tia_multiphase_clock.sv
`default_nettype none
// =============================================================================
// Module : tia_multiphase_clock
// N-phase non-overlapping clock enable generator with hold, resync, frame strobe
// and sticky reset-release latch.
// Rev    : 1.0
// =============================================================================
module tia_multiphase_clock
    import tia_multiphase_clock_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int ON_CYCLES  = 1,
    parameter int OFF_CYCLES = 1,
    localparam int PW        = phase_width(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic                  en,
    input  logic                  sync,
    output logic [NUM_PHASES-1:0] phi,
    output logic [PW-1:0]         phase,
    output logic                  bq,
    output logic                  sof,
    output logic                  rl
);

    localparam int              CW           = cnt_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [CW-1:0]   c_ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0]   c_OFF_LAST   = CW'((OFF_CYCLES > 0) ? (OFF_CYCLES - 1) : 0);
    localparam logic [PW-1:0]   c_PHASE_LAST = PW'(NUM_PHASES - 1);
    localparam logic [PW-1:0]   c_BQ_LIMIT   = PW'(NUM_PHASES / 2);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PW-1:0]           r_phase;
    logic [PW-1:0]           w_phase_nxt;
    logic [PW-1:0]           w_phase_inc;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [NUM_PHASES-1:0]   r_phi;
    logic [NUM_PHASES-1:0]   w_phi_nxt;
    logic                    r_bq;
    logic                    w_bq_nxt;
    logic                    r_sof;
    logic                    w_sof_nxt;
    logic                    w_rl_set;

    assign w_phase_inc = (r_phase == c_PHASE_LAST) ? '0 : r_phase + PW'(1);

    // Leaving RESET and sync both bypass en; sof marks every entry to phase 0 ON.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_sof_nxt   = 1'b0;
        if (sync || (r_state == ST_RESET)) begin
            w_state_nxt = ST_ON;
            w_phase_nxt = '0;
            w_cnt_nxt   = '0;
            w_sof_nxt   = 1'b1;
        end else if (en) begin
            case (r_state)
                ST_ON: begin
                    if (r_cnt == c_ON_LAST) begin
                        w_cnt_nxt = '0;
                        if (OFF_CYCLES > 0) begin
                            w_state_nxt = ST_OFF;
                        end else begin
                            w_phase_nxt = w_phase_inc;
                            w_sof_nxt   = (w_phase_inc == '0);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_OFF: begin
                    if (r_cnt == c_OFF_LAST) begin
                        w_state_nxt = ST_ON;
                        w_cnt_nxt   = '0;
                        w_phase_nxt = w_phase_inc;
                        w_sof_nxt   = (w_phase_inc == '0);
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: w_state_nxt = ST_RESET;
            endcase
        end
    end

    // Decode from next-state so outputs come straight off flops.
    always_comb begin
        w_phi_nxt = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            w_phi_nxt[k] = (w_state_nxt == ST_ON) && (w_phase_nxt == PW'(k));
        end
    end

    assign w_bq_nxt = (w_state_nxt != ST_RESET) && (w_phase_nxt < c_BQ_LIMIT);

    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= ST_RESET;
            r_phase <= '0;
            r_cnt   <= '0;
            r_phi   <= '0;
            r_bq    <= 1'b0;
            r_sof   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phi   <= w_phi_nxt;
            r_bq    <= w_bq_nxt;
            r_sof   <= w_sof_nxt;
        end
    end

    assign w_rl_set = ~r_bq;

    tia_multiphase_clock_sync_sr u_rl_latch (
        .clk (clk),
        .r   (r),
        .s   (w_rl_set),
        .q   (rl)
    );

    assign phi   = r_phi;
    assign phase = r_phase;
    assign bq    = r_bq;
    assign sof   = r_sof;

endmodule
`default_nettype wire

// File: tb/tb_tia_multiphase_clock.sv
`default_nettype none
// =============================================================================
// Module : tb_tia_multiphase_clock
// Three configurations (2/1/1, 4/2/1, 3/1/0) driven together against a
// period-position reference model.
// Rev    : 1.0
// =============================================================================
module tb_tia_multiphase_clock;

    logic clk = 1'b0;
    logic r = 1'b1;
    logic en = 1'b1;
    logic sync = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] phi_a;  logic [0:0] phase_a;  logic bq_a, sof_a, rl_a;
    logic [3:0] phi_b;  logic [1:0] phase_b;  logic bq_b, sof_b, rl_b;
    logic [2:0] phi_c;  logic [1:0] phase_c;  logic bq_c, sof_c, rl_c;

    tia_multiphase_clock #(.NUM_PHASES(2), .ON_CYCLES(1), .OFF_CYCLES(1)) u_a (
        .clk(clk), .r(r), .en(en), .sync(sync),
        .phi(phi_a), .phase(phase_a), .bq(bq_a), .sof(sof_a), .rl(rl_a));
    tia_multiphase_clock #(.NUM_PHASES(4), .ON_CYCLES(2), .OFF_CYCLES(1)) u_b (
        .clk(clk), .r(r), .en(en), .sync(sync),
        .phi(phi_b), .phase(phase_b), .bq(bq_b), .sof(sof_b), .rl(rl_b));
    tia_multiphase_clock #(.NUM_PHASES(3), .ON_CYCLES(1), .OFF_CYCLES(0)) u_c (
        .clk(clk), .r(r), .en(en), .sync(sync),
        .phi(phi_c), .phase(phase_c), .bq(bq_c), .sof(sof_c), .rl(rl_c));

    int checks = 0;
    int failures = 0;

    int cfg_n[3]   = '{2, 4, 3};
    int cfg_on[3]  = '{1, 2, 1};
    int cfg_off[3] = '{1, 1, 0};

    // Model: position t within the period, or the reset condition.
    int t[3]      = '{0, 0, 0};
    bit in_rst[3] = '{1'b1, 1'b1, 1'b1};
    bit m_sof[3]  = '{1'b0, 1'b0, 1'b0};
    bit m_rl[3]   = '{1'b0, 1'b0, 1'b0};

    function automatic int exp_phase(input int i);
        return in_rst[i] ? 0 : t[i] / (cfg_on[i] + cfg_off[i]);
    endfunction

    function automatic int exp_phi(input int i);
        if (in_rst[i] || ((t[i] % (cfg_on[i] + cfg_off[i])) >= cfg_on[i]))
            return 0;
        return 1 << exp_phase(i);
    endfunction

    function automatic int exp_bq(input int i);
        return (!in_rst[i] && (exp_phase(i) < cfg_n[i] / 2)) ? 1 : 0;
    endfunction

    function automatic logic [31:0] obs_phi(input int i);
        case (i)
            0:       return 32'(phi_a);
            1:       return 32'(phi_b);
            default: return 32'(phi_c);
        endcase
    endfunction

    function automatic logic [31:0] obs_phase(input int i);
        case (i)
            0:       return 32'(phase_a);
            1:       return 32'(phase_b);
            default: return 32'(phase_c);
        endcase
    endfunction

    function automatic logic [2:0] obs_flags(input int i);
        case (i)
            0:       return {bq_a, sof_a, rl_a};
            1:       return {bq_b, sof_b, rl_b};
            default: return {bq_c, sof_c, rl_c};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int p;
            p = cfg_n[i] * (cfg_on[i] + cfg_off[i]);
            if (r) begin
                in_rst[i] = 1'b1;
                t[i]      = 0;
                m_sof[i]  = 1'b0;
                m_rl[i]   = 1'b0;
            end else begin
                if (exp_bq(i) == 0) m_rl[i] = 1'b1;
                if (sync || in_rst[i]) begin
                    in_rst[i] = 1'b0;
                    t[i]      = 0;
                    m_sof[i]  = 1'b1;
                end else if (en) begin
                    t[i]     = (t[i] + 1) % p;
                    m_sof[i] = (t[i] == 0);
                end else begin
                    m_sof[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            logic [2:0] f;
            f = obs_flags(i);
            check($sformatf("cfg%0d phi", i), obs_phi(i), 32'(exp_phi(i)));
            check($sformatf("cfg%0d phase", i), obs_phase(i), 32'(exp_phase(i)));
            check($sformatf("cfg%0d bq", i), 32'(f[2]), 32'(exp_bq(i)));
            check($sformatf("cfg%0d sof", i), 32'(f[1]), 32'(m_sof[i]));
            check($sformatf("cfg%0d rl", i), 32'(f[0]), 32'(m_rl[i]));
            check($sformatf("cfg%0d onehot0", i), 32'($onehot0(obs_phi(i))), 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int k;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst phi_a", 32'(phi_a), 32'd0);
        check("rst rl_a", 32'(rl_a), 32'd0);
        check("rst bq_b", 32'(bq_b), 32'd0);

        // Reset release, reference config and no-gap config
        r = 1'b0;
        tick();
        check("rel1 phi_a", 32'(phi_a), 32'd1);
        check("rel1 sof_a", 32'(sof_a), 32'd1);
        check("rel1 bq_a", 32'(bq_a), 32'd1);
        check("rel1 rl_a", 32'(rl_a), 32'd1);
        check("rel1 phi_c", 32'(phi_c), 32'd1);
        tick();
        check("rel2 phi_a", 32'(phi_a), 32'd0);
        check("rel2 phi_c", 32'(phi_c), 32'd2);
        tick();
        check("rel3 phi_a", 32'(phi_a), 32'd2);
        check("rel3 bq_a", 32'(bq_a), 32'd0);
        check("rel3 phi_c", 32'(phi_c), 32'd4);
        tick();
        check("rel4 phi_c", 32'(phi_c), 32'd1);
        check("rel4 sof_c", 32'(sof_c), 32'd1);
        tick();
        check("rel5 phi_a", 32'(phi_a), 32'd1);
        repeat (20) tick();

        // Hold while phi_a = 10
        k = 0;
        while (exp_phi(0) != 2 && k < 20) begin tick(); k++; end
        check("hold reach", 32'(k < 20), 32'd1);
        en = 1'b0;
        repeat (5) begin
            tick();
            check("hold phi_a", 32'(phi_a), 32'd2);
            check("hold sof_a", 32'(sof_a), 32'd0);
        end
        en = 1'b1;
        tick();
        check("resume phi_a", 32'(phi_a), 32'd0);
        tick();
        check("resume2 phi_a", 32'(phi_a), 32'd1);
        check("resume2 sof_a", 32'(sof_a), 32'd1);

        // Sync during phase 2 OFF of 4/2/1, with en=1 and then en=0
        for (int pass = 0; pass < 2; pass++) begin
            k = 0;
            while ((in_rst[1] || t[1] != 8) && k < 30) begin tick(); k++; end
            check("sync reach", 32'(k < 30), 32'd1);
            sync = 1'b1;
            en = (pass == 0);
            tick();
            sync = 1'b0;
            en = 1'b1;
            check("sync phi_b", 32'(phi_b), 32'd1);
            check("sync phase_b", 32'(phase_b), 32'd0);
            check("sync sof_b", 32'(sof_b), 32'd1);
        end

        // Reset during phase 1 ON of 4/2/1
        k = 0;
        while (!(t[1] == 3 || t[1] == 4) && k < 30) begin tick(); k++; end
        check("rstmid reach", 32'(k < 30), 32'd1);
        r = 1'b1;
        tick();
        r = 1'b0;
        check("rstmid phi_b", 32'(phi_b), 32'd0);
        check("rstmid bq_b", 32'(bq_b), 32'd0);
        check("rstmid rl_b", 32'(rl_b), 32'd0);
        check("rstmid sof_b", 32'(sof_b), 32'd0);
        tick();
        check("restart phi_b", 32'(phi_b), 32'd1);
        check("restart sof_b", 32'(sof_b), 32'd1);
        check("restart rl_b", 32'(rl_b), 32'd1);
        repeat (4) tick();

        // Reset and sync together
        r = 1'b1;
        sync = 1'b1;
        tick();
        r = 1'b0;
        sync = 1'b0;
        check("rsync phi_b", 32'(phi_b), 32'd0);
        check("rsync sof_b", 32'(sof_b), 32'd0);
        tick();
        check("rsync rel phi_b", 32'(phi_b), 32'd1);

        // Randomised traffic
        repeat (400) begin
            r    = ($urandom_range(0, 49) == 0);
            sync = ($urandom_range(0, 29) == 0);
            en   = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
